// File: rtl/zapper_hit_sequencer.sv
// zapper_hit_sequencer: sequences one light-gun shot from trigger press to a
// hit/miss verdict. Blanks the screen, shows the duck hit-box, integrates the
// photodiode in each phase and raises a single-cycle verdict pulse.
module zapper_hit_sequencer #(
  parameter logic [2:0] PLAY_STATE      = 3'd2,
  parameter int         BLACK_FRAMES    = 1,
  parameter int         TARGET_FRAMES   = 1,
  parameter int         COOLDOWN_FRAMES = 4,
  parameter int         DEBOUNCE_CYCLES = 50000,
  parameter int         SENSE_MIN       = 16
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       trigger,
  input  logic       light_sense,
  input  logic [2:0] state,
  input  logic       no_shots_left,
  output logic       shot,
  output logic       flash_black,
  output logic       flash_target,
  output logic       bird_shot,
  output logic       miss,
  output logic       busy
);

  localparam int FRAME_MAX_BT = (BLACK_FRAMES > TARGET_FRAMES) ? BLACK_FRAMES : TARGET_FRAMES;
  localparam int FRAME_MAX    = (FRAME_MAX_BT > COOLDOWN_FRAMES) ? FRAME_MAX_BT : COOLDOWN_FRAMES;
  localparam int FCW          = $clog2(FRAME_MAX + 1);
  localparam int DBW          = $clog2(DEBOUNCE_CYCLES + 1);

  // Terminal values are "last count before the limit" so the tick that
  // completes the phase is the one that moves the FSM on.
  localparam logic [FCW-1:0] BLACK_LAST  = FCW'(BLACK_FRAMES - 1);
  localparam logic [FCW-1:0] TARGET_LAST = FCW'(TARGET_FRAMES - 1);
  localparam logic [FCW-1:0] COOL_LAST   = FCW'(COOLDOWN_FRAMES - 1);
  localparam logic [DBW-1:0] DB_LAST     = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0]    SENSE_MIN_C = 16'(SENSE_MIN);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARM      = 3'd1,
    ST_BLACK    = 3'd2,
    ST_TARGET   = 3'd3,
    ST_DECIDE   = 3'd4,
    ST_COOLDOWN = 3'd5
  } fsm_t;

  fsm_t           fsm_r;
  logic           trig_meta_r, trig_sync_r;
  logic           light_meta_r, light_sync_r;
  logic           frame_meta_r, frame_sync_r, frame_prev_r;
  logic           frame_tick_r;
  logic [DBW-1:0] db_cnt_r;
  logic           trig_db_r, trig_db_d_r;
  logic [FCW-1:0] frame_cnt_r;
  logic [15:0]    light_cnt_r;
  logic           ambient_r;
  logic [15:0]    light_nxt_s;
  logic           trig_rise_s;
  logic           in_play_s;

  assign trig_rise_s = trig_db_r & ~trig_db_d_r;
  assign in_play_s   = (state == PLAY_STATE);

  // Two-flop synchronisers for the three asynchronous inputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      trig_meta_r  <= 1'b0;
      trig_sync_r  <= 1'b0;
      light_meta_r <= 1'b0;
      light_sync_r <= 1'b0;
      frame_meta_r <= 1'b0;
      frame_sync_r <= 1'b0;
    end else begin
      trig_meta_r  <= trigger;
      trig_sync_r  <= trig_meta_r;
      light_meta_r <= light_sense;
      light_sync_r <= light_meta_r;
      frame_meta_r <= frame_clk;
      frame_sync_r <= frame_meta_r;
    end
  end

  // Registered rising-edge detect of the synchronised vertical sync.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      frame_prev_r <= 1'b0;
      frame_tick_r <= 1'b0;
    end else begin
      frame_prev_r <= frame_sync_r;
      frame_tick_r <= frame_sync_r & ~frame_prev_r;
    end
  end

  // Trigger debounce: the filtered level follows only after a full run of
  // consecutive disagreeing samples; any agreeing sample restarts the run.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      db_cnt_r    <= {DBW{1'b0}};
      trig_db_r   <= 1'b0;
      trig_db_d_r <= 1'b0;
    end else begin
      trig_db_d_r <= trig_db_r;
      if (trig_sync_r != trig_db_r) begin
        if (db_cnt_r == DB_LAST) begin
          trig_db_r <= trig_sync_r;
          db_cnt_r  <= {DBW{1'b0}};
        end else begin
          db_cnt_r  <= db_cnt_r + DBW'(1);
        end
      end else begin
        db_cnt_r <= {DBW{1'b0}};
      end
    end
  end

  // Saturating light integrator next value, including this cycle's sample.
  always_comb begin
    light_nxt_s = light_cnt_r;
    if (light_sync_r && (light_cnt_r != 16'hFFFF)) begin
      light_nxt_s = light_cnt_r + 16'd1;
    end else begin
      light_nxt_s = light_cnt_r;
    end
  end

  // Shot sequencing FSM with all outputs registered; leaving play aborts.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      fsm_r        <= ST_IDLE;
      frame_cnt_r  <= {FCW{1'b0}};
      light_cnt_r  <= 16'd0;
      ambient_r    <= 1'b0;
      shot         <= 1'b0;
      flash_black  <= 1'b0;
      flash_target <= 1'b0;
      bird_shot    <= 1'b0;
      miss         <= 1'b0;
      busy         <= 1'b0;
    end else begin
      shot      <= 1'b0;
      bird_shot <= 1'b0;
      miss      <= 1'b0;
      case (fsm_r)
        ST_IDLE: begin
          if (trig_rise_s && in_play_s && !no_shots_left) begin
            shot  <= 1'b1;
            busy  <= 1'b1;
            fsm_r <= ST_ARM;
          end else begin
            fsm_r <= ST_IDLE;
          end
        end
        ST_ARM: begin
          if (!in_play_s) begin
            busy  <= 1'b0;
            fsm_r <= ST_IDLE;
          end else if (frame_tick_r) begin
            frame_cnt_r <= {FCW{1'b0}};
            light_cnt_r <= 16'd0;
            flash_black <= 1'b1;
            fsm_r       <= ST_BLACK;
          end else begin
            fsm_r <= ST_ARM;
          end
        end
        ST_BLACK: begin
          if (!in_play_s) begin
            flash_black <= 1'b0;
            busy        <= 1'b0;
            fsm_r       <= ST_IDLE;
          end else if (frame_tick_r && (frame_cnt_r == BLACK_LAST)) begin
            ambient_r    <= (light_nxt_s >= SENSE_MIN_C);
            light_cnt_r  <= 16'd0;
            frame_cnt_r  <= {FCW{1'b0}};
            flash_black  <= 1'b0;
            flash_target <= 1'b1;
            fsm_r        <= ST_TARGET;
          end else begin
            light_cnt_r <= light_nxt_s;
            if (frame_tick_r) begin
              frame_cnt_r <= frame_cnt_r + FCW'(1);
            end else begin
              frame_cnt_r <= frame_cnt_r;
            end
          end
        end
        ST_TARGET: begin
          if (!in_play_s) begin
            flash_target <= 1'b0;
            busy         <= 1'b0;
            fsm_r        <= ST_IDLE;
          end else if (frame_tick_r && (frame_cnt_r == TARGET_LAST)) begin
            light_cnt_r  <= light_nxt_s;
            frame_cnt_r  <= {FCW{1'b0}};
            flash_target <= 1'b0;
            fsm_r        <= ST_DECIDE;
          end else begin
            light_cnt_r <= light_nxt_s;
            if (frame_tick_r) begin
              frame_cnt_r <= frame_cnt_r + FCW'(1);
            end else begin
              frame_cnt_r <= frame_cnt_r;
            end
          end
        end
        ST_DECIDE: begin
          if (!in_play_s) begin
            busy  <= 1'b0;
            fsm_r <= ST_IDLE;
          end else begin
            // A bright black frame means the gun saw a lamp, not the screen.
            if (!ambient_r && (light_cnt_r >= SENSE_MIN_C)) begin
              bird_shot <= 1'b1;
            end else begin
              miss <= 1'b1;
            end
            frame_cnt_r <= {FCW{1'b0}};
            fsm_r       <= ST_COOLDOWN;
          end
        end
        ST_COOLDOWN: begin
          if (frame_tick_r) begin
            if (frame_cnt_r == COOL_LAST) begin
              frame_cnt_r <= {FCW{1'b0}};
              busy        <= 1'b0;
              fsm_r       <= ST_IDLE;
            end else begin
              frame_cnt_r <= frame_cnt_r + FCW'(1);
            end
          end else begin
            frame_cnt_r <= frame_cnt_r;
          end
        end
        default: begin
          flash_black  <= 1'b0;
          flash_target <= 1'b0;
          busy         <= 1'b0;
          frame_cnt_r  <= {FCW{1'b0}};
          light_cnt_r  <= 16'd0;
          fsm_r        <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_zapper_hit_sequencer.sv
// Bench for zapper_hit_sequencer: table-driven shots, randomized shots checked
// against a verdict model, and hand-written gating/abort/reset/cooldown cases.
module tb_zapper_hit_sequencer;

  localparam int P    = 200;  // frame period in Clk cycles
  localparam int DEB  = 20;   // shortened debounce for simulation
  localparam int SMIN = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_clk;
  logic       trigger = 1'b0;
  logic       light = 1'b0;
  logic [2:0] st = 3'd2;
  logic       nsl = 1'b0;
  logic       shot, flash_black, flash_target, bird_shot, miss, busy;

  int compares = 0;
  int fails = 0;
  int shot_count = 0, bird_count = 0, miss_count = 0, overlap = 0, dual = 0;

  typedef struct {
    int black_n;
    int tgt_n;
    bit full;
    bit exp_hit;
  } vec_t;

  vec_t vecs[8];

  zapper_hit_sequencer #(
    .PLAY_STATE(3'd2), .BLACK_FRAMES(1), .TARGET_FRAMES(1),
    .COOLDOWN_FRAMES(4), .DEBOUNCE_CYCLES(DEB), .SENSE_MIN(SMIN)
  ) dut (
    .Clk(clk), .Reset(rst), .frame_clk(frame_clk), .trigger(trigger),
    .light_sense(light), .state(st), .no_shots_left(nsl),
    .shot(shot), .flash_black(flash_black), .flash_target(flash_target),
    .bird_shot(bird_shot), .miss(miss), .busy(busy)
  );

  always #5 clk = ~clk;

  // Free-running VGA vertical sync, exactly P Clk cycles per frame.
  always begin
    frame_clk = 1'b1;
    repeat (20) @(negedge clk);
    frame_clk = 1'b0;
    repeat (P - 20) @(negedge clk);
  end

  // Pulse counters and illegal-overlap monitors.
  always @(negedge clk) begin
    if (shot) shot_count <= shot_count + 1;
    if (bird_shot) bird_count <= bird_count + 1;
    if (miss) miss_count <= miss_count + 1;
    if (flash_black && flash_target) overlap <= overlap + 1;
    if (bird_shot && miss) dual <= dual + 1;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input int act, input int exp);
    compares++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference verdict: the black frame must be dark and the target bright.
  function automatic bit model_hit(input int black_n, input int tgt_n, input bit full);
    if (full) return 1'b0;
    return (black_n < SMIN) && (tgt_n >= SMIN);
  endfunction

  function automatic bit sig_now(input int which);
    case (which)
      0: return flash_black;
      1: return flash_target;
      2: return bird_shot | miss;
      3: return !busy;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_sig(input int which, input int limit, output bit ok, output int n);
    ok = 1'b0;
    n = 0;
    for (int i = 0; i < limit; i++) begin
      if (sig_now(which)) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      n++;
    end
  endtask

  task automatic press(output bit got);
    got = 1'b0;
    trigger = 1'b1;
    for (int i = 0; i < DEB + 10; i++) begin
      @(negedge clk);
      if (shot) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic release_trig();
    trigger = 1'b0;
    repeat (DEB + 10) @(negedge clk);
  endtask

  task automatic run_shot(input string name, input int black_n, input int tgt_n,
                          input bit full, input bit exp_hit, input bit do_cool);
    bit ok, got;
    int w, n;
    light = full;
    press(got);
    trigger = 1'b0;
    check({name, "_shot"}, got, 1);
    wait_sig(0, 3 * P, ok, n);
    check({name, "_black_seen"}, ok, 1);
    if (!ok) begin
      light = 1'b0;
      return;
    end
    w = 1;
    while (flash_black && w < 3 * P) begin
      light = full || (w >= 10 && w < 10 + black_n);
      @(negedge clk);
      if (flash_black) w++;
    end
    light = full;
    check({name, "_black_width"}, w, P);
    check({name, "_target_on"}, flash_target, 1);
    w = 1;
    while (flash_target && w < 3 * P) begin
      light = full || (w >= 10 && w < 10 + tgt_n);
      @(negedge clk);
      if (flash_target) w++;
    end
    light = full;
    check({name, "_target_width"}, w, P);
    wait_sig(2, 4, ok, n);
    check({name, "_verdict_seen"}, ok, 1);
    check({name, "_bird_shot"}, bird_shot, exp_hit);
    check({name, "_miss"}, miss, !exp_hit);
    light = 1'b0;
    @(negedge clk);
    check({name, "_pulse_1cyc"}, bird_shot | miss, 0);
    if (do_cool) begin
      wait_sig(3, 5 * P, ok, n);
      n = n + 1;
      check({name, "_cooldown_len"}, (ok && n >= 4 * P - 5 && n <= 4 * P + 5), 1);
    end
  endtask

  initial begin
    bit got, ok;
    int n, s0, b0, m0, bn, tn;

    vecs[0] = '{0, 100, 1'b0, 1'b1};  // clean hit
    vecs[1] = '{0, 15, 1'b0, 1'b0};   // one short of SENSE_MIN
    vecs[2] = '{0, 16, 1'b0, 1'b1};   // exactly SENSE_MIN
    vecs[3] = '{100, 100, 1'b0, 1'b0};  // bright black frame
    vecs[4] = '{0, 0, 1'b1, 1'b0};    // light held through whole sequence
    vecs[5] = '{15, 16, 1'b0, 1'b1};  // dim ambient just below threshold
    vecs[6] = '{16, 60, 1'b0, 1'b0};  // ambient just at threshold
    vecs[7] = '{0, 0, 1'b0, 1'b0};    // no light at all

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_flash", flash_black | flash_target, 0);
    check("rst_pulses", shot | bird_shot | miss, 0);
    rst = 1'b0;
    repeat (P) @(negedge clk);
    check("post_rst_busy", busy, 0);

    // Table-driven shots
    for (int i = 0; i < 8; i++) begin
      run_shot($sformatf("vec%0d", i), vecs[i].black_n, vecs[i].tgt_n,
               vecs[i].full, vecs[i].exp_hit, 1'b1);
    end

    // Randomized shots against the verdict model
    for (int i = 0; i < 6; i++) begin
      bn = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 15) : $urandom_range(16, 60);
      tn = $urandom_range(0, 60);
      run_shot($sformatf("rnd%0d", i), bn, tn, 1'b0, model_hit(bn, tn, 1'b0), 1'b1);
    end

    // Bounce shorter than the debounce window
    s0 = shot_count;
    for (int i = 0; i < 40; i++) begin
      trigger = ~trigger;
      repeat (DEB / 2) @(negedge clk);
    end
    trigger = 1'b0;
    repeat (DEB + 10) @(negedge clk);
    check("bounce_no_shot", shot_count - s0, 0);
    check("bounce_idle", busy, 0);

    // Out of shots
    nsl = 1'b1;
    press(got);
    check("noshots_no_shot", got, 0);
    check("noshots_idle", busy, 0);
    release_trig();
    nsl = 1'b0;

    // Not in play state
    st = 3'd0;
    press(got);
    check("state0_no_shot", got, 0);
    check("state0_idle", busy, 0);
    release_trig();
    st = 3'd2;

    // Abort during TARGET
    press(got);
    trigger = 1'b0;
    check("abort_shot", got, 1);
    wait_sig(1, 3 * P, ok, n);
    check("abort_target_seen", ok, 1);
    b0 = bird_count;
    m0 = miss_count;
    st = 3'd4;
    @(negedge clk);
    check("abort_target_off", flash_target, 0);
    check("abort_idle", busy, 0);
    repeat (2 * P) @(negedge clk);
    check("abort_no_verdict", (bird_count - b0) + (miss_count - m0), 0);
    st = 3'd2;

    // Async reset mid-BLACK
    press(got);
    trigger = 1'b0;
    check("rstmid_shot", got, 1);
    wait_sig(0, 3 * P, ok, n);
    check("rstmid_black_seen", ok, 1);
    b0 = bird_count;
    m0 = miss_count;
    #2 rst = 1'b1;
    #1;
    check("rstmid_flash", flash_black | flash_target, 0);
    check("rstmid_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2 * P) @(negedge clk);
    check("rstmid_no_verdict", (bird_count - b0) + (miss_count - m0), 0);
    check("rstmid_idle", busy, 0);

    // Cooldown: press one frame after the verdict is dropped
    run_shot("cool_a", 0, 50, 1'b0, 1'b1, 1'b0);
    repeat (P) @(negedge clk);
    press(got);
    check("cool_ignored", got, 0);
    release_trig();
    wait_sig(3, 5 * P, ok, n);
    check("cool_end", ok, 1);
    run_shot("cool_b", 0, 0, 1'b0, 1'b0, 1'b1);

    check("no_flash_overlap", overlap, 0);
    check("no_dual_verdict", dual, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", compares, fails);
    $finish;
  end

endmodule

// File: doc/zapper_hit_sequencer.md
Name: zapper_hit_sequencer

Overview:
Sequences one light-gun shot from trigger to hit/miss verdict. Blanks the screen for a set number of frames, then has the color mapper draw the duck hit-box, and samples the gun photodiode during each phase. Sits between the gun GPIO inputs and the game controller, shot keeper and color mapper. Drives the single-cycle shot and bird_shot pulses those blocks consume.

Parameters:
PLAY_STATE, 3'd2, game-controller state code in which shots are accepted
BLACK_FRAMES, 1, frames of all-black screen before the target frame (>=1)
TARGET_FRAMES, 1, frames of hit-box-only screen (>=1)
COOLDOWN_FRAMES, 4, frames after the verdict during which the trigger is ignored
DEBOUNCE_CYCLES, 50000, Clk cycles the trigger must be stable (1 ms at 50 MHz)
SENSE_MIN, 16, minimum light-high Clk cycles in one phase to count as "light seen"

Ports:
Clk  input  1  system clock, 50 MHz
Reset  input  1  asynchronous, active-high reset
frame_clk  input  1  VGA_VS; rising edge marks frame boundary
trigger  input  1  raw gun trigger, active high, asynchronous
light_sense  input  1  raw photodiode, high = light, asynchronous
state  input  3  game-controller state
no_shots_left  input  1  from shot keeper; blocks new shots
shot  output  1  1-cycle pulse when a shot is accepted
flash_black  output  1  color mapper forces whole screen black
flash_target  output  1  color mapper draws white hit-box on duck, black elsewhere
bird_shot  output  1  1-cycle pulse, verdict = hit
miss  output  1  1-cycle pulse, verdict = miss
busy  output  1  high whenever FSM not in IDLE

Behaviour:
- Reset (async, active-high): FSM=IDLE, all counters 0, all outputs 0. Reset mid-sequence aborts with no pulses.
- Input conditioning: trigger, light_sense, frame_clk each pass through 2-flop synchronisers.
- frame_tick: 1-cycle pulse on synchronised frame_clk 0->1. Latency 3 Clk cycles from the raw edge.
- Debounce: trig_db changes only after the synchronised trigger differs from trig_db for DEBOUNCE_CYCLES consecutive cycles. Counter clears on any mismatch break. trig_rise = trig_db 0->1.
- FSM states: IDLE, ARM, BLACK, TARGET, DECIDE, COOLDOWN.
- IDLE: on trig_rise with state==PLAY_STATE and no_shots_left==0:
  - shot=1 for that cycle; go to ARM.
  - Any other trig_rise is discarded, not queued.
- ARM: wait for frame_tick, then go to BLACK. frame_cnt=0, light_cnt=0, flash_black=1 from the next cycle.
- BLACK:
  - light_cnt increments (saturating at 16 bits) each cycle the synchronised light_sense is high.
  - On each frame_tick, frame_cnt++. When frame_cnt reaches BLACK_FRAMES:
    - ambient <= (light_cnt>=SENSE_MIN).
    - light_cnt=0, frame_cnt=0.
    - Go to TARGET: flash_black=0, flash_target=1.
- TARGET: same counting. When frame_cnt reaches TARGET_FRAMES, go to DECIDE with flash_target=0.
- DECIDE (exactly 1 cycle):
  - hit = !ambient && light_cnt>=SENSE_MIN.
  - Pulse bird_shot if hit, else pulse miss. Exactly one of the two is raised.
  - Go to COOLDOWN, frame_cnt=0.
- COOLDOWN: count frame_tick. At COOLDOWN_FRAMES go to IDLE. Trigger edges here are dropped.
- Abort: if state!=PLAY_STATE while in ARM/BLACK/TARGET/DECIDE:
  - Next cycle goes to IDLE; flash outputs drop to 0; no bird_shot/miss.
  - A shot already issued is not retracted.
- Outputs: all registered. flash_black and flash_target are never high together. busy = (FSM!=IDLE).
- Simultaneous frame_tick and abort: abort wins.
- Simultaneous trig_rise and no_shots_left rising: no_shots_left is sampled that cycle and blocks the shot.
- Counter widths: frame_cnt $clog2 of max(frame params)+1; debounce counter $clog2(DEBOUNCE_CYCLES+1); light_cnt 16 bits, saturating.

Test Plan:
1. Hit: state=2, trigger held 1 ms, light_sense 0 during BLACK and 100 cycles high during TARGET -> shot pulse once, flash_black for 1 frame then flash_target for 1 frame, bird_shot pulse 1 cycle after the TARGET-ending tick, miss=0, busy drops 4 frames later.
2. Ambient cheat: light_sense high for the entire sequence -> ambient=1, miss pulse, bird_shot=0.
3. Weak light: TARGET light_sense high for 15 cycles (SENSE_MIN=16) -> miss. Repeat with 16 cycles -> bird_shot.
4. Bounce and gating:
   - Trigger toggles every 1000 cycles for 20 µs -> no shot.
   - no_shots_left=1 with a clean press -> no shot, busy stays 0.
   - state=0 with a clean press -> no shot.
5. Abort: state changes 2->4 during TARGET -> flash_target=0 next cycle, FSM IDLE, no bird_shot/miss. Async Reset asserted mid-BLACK -> all outputs 0 immediately.
6. Cooldown: second press 1 frame after the verdict -> ignored, no second shot. A press after 4 frames -> accepted.
